ledg_fade_pwm: RTL and testbench

- Drives the 8 green board LEDs from the 8-bit LED PIO output register (`out_port`).
- Each LED fades smoothly between off and full brightness instead of switching hard. Per-LED brightness is a counter ramped toward the target bit; a shared PWM counter modulates the pins.
- Sits between the PIO `out_port` and the top-level LEDG pins, in the same `clk` domain as the PIO.

---
 rtl/ledg_fade_pwm.sv | 73 +++++++
 tb/tb_ledg_fade_pwm.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ledg_fade_pwm.sv
// ledg_fade_pwm: fades the 8 green board LEDs between off and full brightness
//   clk      in   system clock (same domain as the LED PIO)
//   reset_n  in   asynchronous, active-low reset
//   led_in   in   [7:0] target on/off per LED from the PIO out_port
//   bypass   in   1 = pins follow led_in directly, no fading
//   led_out  out  [7:0] registered drive to the LEDG pins
//   busy     out  1 while any brightness level differs from its target
//   pwm_wrap out  1-cycle pulse at each PWM period end
module ledg_fade_pwm #(
   parameter int unsigned CLK_DIV  = 195,
   parameter int unsigned PWM_BITS = 4,
   parameter int unsigned FADE_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] led_in,
   input  logic       bypass,
   output logic [7:0] led_out,
   output logic       busy,
   output logic       pwm_wrap
);
   localparam int unsigned PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int unsigned FW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [FW-1:0] FCNT_MAX = FW'(FADE_DIV - 1);
   localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
   logic [PW-1:0] presc_q, presc_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [7:0][PWM_BITS-1:0] level_q, level_d, tgt;
   logic [7:0] led_out_d;
   logic tick, wrap, fade_step;
   assign tick      = presc_q == PRESC_MAX;
   assign wrap      = tick && pwm_cnt_q == LVL_MAX;
   assign fade_step = wrap && fcnt_q == FCNT_MAX;
   always_comb begin
      presc_d   = tick ? '0 : presc_q + PW'(1);
      pwm_cnt_d = !tick ? pwm_cnt_q : pwm_cnt_q == LVL_MAX ? '0 : pwm_cnt_q + PWM_BITS'(1);
      fcnt_d    = !wrap ? fcnt_q : fade_step ? '0 : fcnt_q + FW'(1);
      tgt       = '0;
      level_d   = level_q;
      led_out_d = '0;
      busy      = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tgt[i]       = led_in[i] ? LVL_MAX : '0;
         // bypass snaps levels to their targets so leaving bypass cannot glitch
         level_d[i]   = bypass ? tgt[i] :
                        !fade_step ? level_q[i] :
                        level_q[i] < tgt[i] ? level_q[i] + PWM_BITS'(1) :
                        level_q[i] > tgt[i] ? level_q[i] - PWM_BITS'(1) : level_q[i];
         // full level is forced on: pwm_cnt < LVL_MAX alone would drop one count
         led_out_d[i] = bypass ? led_in[i] : (level_q[i] == LVL_MAX) | (pwm_cnt_q < level_q[i]);
         busy         = busy | (level_q[i] != tgt[i]);
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
         fcnt_q    <= '0;
         level_q   <= '0;
         led_out   <= '0;
         pwm_wrap  <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
         fcnt_q    <= fcnt_d;
         level_q   <= level_d;
         led_out   <= led_out_d;
         pwm_wrap  <= wrap;
      end
   end
endmodule

// File: tb/tb_ledg_fade_pwm.sv
// tb_ledg_fade_pwm: scoreboard bench for ledg_fade_pwm (CLK_DIV=2, PWM_BITS=4, FADE_DIV=1)
module tb_ledg_fade_pwm;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic bypass = 1'b0;
   logic [7:0] led_in = '0;
   logic [7:0] led_out;
   logic busy, pwm_wrap;
   int n_chk = 0;
   int n_err = 0;
   int cnt [8];
   int mlev [8];
   bit sb_en = 1'b0;
   logic [47:0] sb_q [$];
   always #5 clk = ~clk;
   ledg_fade_pwm #(.CLK_DIV(2), .PWM_BITS(4), .FADE_DIV(1)) dut (
      .clk(clk), .reset_n(reset_n), .led_in(led_in), .bypass(bypass),
      .led_out(led_out), .busy(busy), .pwm_wrap(pwm_wrap)
   );
   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // expected high-clk count per LED over one 32-clk PWM period, 6 bits per lane
   function automatic logic [47:0] exp_pack();
      logic [47:0] e = '0;
      for (int i = 0; i < 8; i++) e[i*6 +: 6] = (mlev[i] == 15) ? 6'd32 : 6'(2 * mlev[i]);
      return e;
   endfunction
   always @(posedge clk) begin
      logic [47:0] obs, exp;
      #1;
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) cnt[i] = 0;
      end else begin
         for (int i = 0; i < 8; i++) cnt[i] += int'(led_out[i]);
         if (pwm_wrap) begin
            if (sb_en) begin
               obs = '0;
               for (int i = 0; i < 8; i++) obs[i*6 +: 6] = 6'(cnt[i]);
               exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
               chk("duty", obs, exp);
            end
            for (int i = 0; i < 8; i++) cnt[i] = 0;
         end
      end
   end
   // one PWM period with led_in=val; the model steps once at its end
   task automatic window(input logic [7:0] val);
      int waited = 0;
      int t;
      led_in = val;
      sb_q.push_back(exp_pack());
      for (int i = 0; i < 8; i++) begin
         t = val[i] ? 15 : 0;
         if (mlev[i] < t) mlev[i]++;
         else if (mlev[i] > t) mlev[i]--;
      end
      do begin
         @(negedge clk);
         waited++;
      end while (!pwm_wrap && waited < 100);
      chk("period", 48'(waited), 48'd32);
   endtask
   task automatic run(input logic [7:0] val, input int n);
      for (int k = 0; k < n; k++) window(val);
   endtask
   initial begin
      int k;
      led_in = 8'hFF;
      repeat (3) @(negedge clk);
      chk("rst_led", 48'(led_out), 48'h0);
      chk("rst_wrap", 48'(pwm_wrap), 48'h0);
      chk("rst_busy", 48'(busy), 48'h1);
      reset_n = 1'b1;
      sb_en = 1'b1;
      for (int i = 0; i < 8; i++) mlev[i] = 0;
      run(8'hFF, 1);
      run(8'h00, 1);
      for (int j = 0; j < 16; j++) begin
         window(8'h01);
         if (j == 5) chk("busy_mid", 48'(busy), 48'h1);
      end
      chk("busy_full", 48'(busy), 48'h0);
      run(8'h00, 15);
      chk("busy_rest", 48'(busy), 48'h0);
      run(8'h01, 6);
      run(8'h00, 7);
      chk("busy_rev", 48'(busy), 48'h0);
      chk("led_rev", 48'(led_out), 48'h0);
      run(8'hA5, 8);
      sb_en = 1'b0;
      bypass = 1'b1;
      led_in = 8'h3C;
      @(negedge clk);
      chk("byp_led", 48'(led_out), 48'h3C);
      chk("byp_busy", 48'(busy), 48'h0);
      repeat (10) @(negedge clk);
      bypass = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         chk("byp_exit", 48'(led_out), 48'h3C);
      end
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!pwm_wrap && k < 64);
      chk("realign", 48'(pwm_wrap), 48'h1);
      for (int i = 0; i < 8; i++) mlev[i] = (i >= 2 && i <= 5) ? 15 : 0;
      sb_en = 1'b1;
      run(8'h00, 16);
      run(8'h01, 9);
      sb_en = 1'b0;
      @(negedge clk);
      chk("pre_rst", 48'(led_out), 48'h01);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_async", 48'(led_out), 48'h0);
      chk("rst_busy2", 48'(busy), 48'h1);
      repeat (3) @(negedge clk);
      sb_q.delete();
      for (int i = 0; i < 8; i++) mlev[i] = 0;
      reset_n = 1'b1;
      sb_en = 1'b1;
      run(8'h01, 3);
      chk("sb_drain", 48'(sb_q.size()), 48'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
